// File: rtl/btn_pulse_cond.sv
// Button conditioning ahead of the two-button lock: sync, debounce, press arbitration.
// Latency: a held raw change flips the stable level SYNC_STAGES+DEBOUNCE_CYCLES-1 edges later; pulse one edge after.
// No backpressure; optional sticky conflict flag via `define BTN_CONFLICT_STICKY_EN.
module btn_pulse_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn0_raw,
  input  logic btn1_raw,
  output logic pulse0,
  output logic pulse1,
  output logic busy,
  output logic conflict
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2,
    BOTH  = 2'd3
  } state_t;

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [1:0]             s;
  logic [1:0]             stable_q;
  logic [1:0]             stable_d_q;
  logic [1:0]             armed_q;
  logic [1:0]             rise;
  logic                   filled;
  state_t                 state_q;

  assign raw    = {btn1_raw, btn0_raw};
  assign s      = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
  assign filled = fill_q[SYNC_STAGES-1];

  // A press only counts once the button has been seen released since reset, so a
  // button held through reset cannot produce a pulse until it is let go and re-pressed.
  assign rise = stable_q & ~stable_d_q & armed_q;

  // Marks the point after reset where the synchronizer outputs reflect real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= '0;
    end else begin
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Per-button synchronizer, debounce counter, stable level and release-arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q   <= '0;
      stable_d_q <= '0;
      armed_q    <= '0;
    end else begin
      stable_d_q <= stable_q;
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (s[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            stable_q[i] <= s[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          // Any sample agreeing with the stable level restarts the count.
          cnt_q[i] <= '0;
        end
        if (filled && !s[i] && !stable_q[i]) begin
          armed_q[i] <= 1'b1;
        end
      end
    end
  end

  // Arbiter: single accepted press per episode, overlap suppresses pulses and flags conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pulse0   <= 1'b0;
      pulse1   <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      pulse0 <= 1'b0;
      pulse1 <= 1'b0;
`ifndef BTN_CONFLICT_STICKY_EN
      conflict <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (rise[0] && rise[1]) begin
            state_q  <= BOTH;
            busy     <= 1'b1;
            conflict <= 1'b1;
          end else if (rise[0]) begin
            state_q <= HOLD0;
            busy    <= 1'b1;
            pulse0  <= 1'b1;
`ifdef BTN_CONFLICT_STICKY_EN
            conflict <= 1'b0;
`endif
          end else if (rise[1]) begin
            state_q <= HOLD1;
            busy    <= 1'b1;
            pulse1  <= 1'b1;
`ifdef BTN_CONFLICT_STICKY_EN
            conflict <= 1'b0;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        HOLD0: begin
          if (rise[1]) begin
            state_q  <= BOTH;
            conflict <= 1'b1;
          end else if (!stable_q[0] && !stable_q[1]) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        HOLD1: begin
          if (rise[0]) begin
            state_q  <= BOTH;
            conflict <= 1'b1;
          end else if (!stable_q[0] && !stable_q[1]) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        BOTH: begin
          if (!stable_q[0] && !stable_q[1]) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_pulse_cond.sv
// Self-checking bench for btn_pulse_cond: vector table, corner sequences, random vs reference model.
module tb_btn_pulse_cond;

  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn0_raw;
  logic btn1_raw;
  logic pulse0;
  logic pulse1;
  logic busy;
  logic conflict;

  int n_chk = 0;
  int n_err = 0;
  int c_p0, c_p1, c_conf, c_ovl;

  typedef struct {
    logic b0;
    logic b1;
    logic p0;
    logic p1;
    logic bsy;
    logic conf;
  } vec_t;

  vec_t tbl [48];

  btn_pulse_cond #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn0_raw(btn0_raw),
    .btn1_raw(btn1_raw),
    .pulse0  (pulse0),
    .pulse1  (pulse1),
    .busy    (busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: debounced level = flips once the last D synchronized samples all
  // disagree with it; arbitration tracked as episodes of "any button stably held".
  bit mh [2][S+D];
  bit mst [2];
  bit mst_d [2];
  bit m_in_ep;
  int m_rises;
  bit e_p0, e_p1, e_busy, e_conf;
  int r0, r1;
  bit cevt, allx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < S + D; j++) mh[b][j] = 1'b0;
        mst[b]   = 1'b0;
        mst_d[b] = 1'b0;
      end
      m_in_ep = 1'b0;
      m_rises = 0;
      e_p0 = 1'b0; e_p1 = 1'b0; e_busy = 1'b0; e_conf = 1'b0;
    end else begin
      r0 = (mst[0] && !mst_d[0]) ? 1 : 0;
      r1 = (mst[1] && !mst_d[1]) ? 1 : 0;
      e_p0 = 1'b0; e_p1 = 1'b0; cevt = 1'b0;
      if (!m_in_ep) begin
        if (r0 + r1 > 0) begin
          m_in_ep = 1'b1;
          m_rises = r0 + r1;
          e_p0 = (r0 + r1 == 1) && (r0 == 1);
          e_p1 = (r0 + r1 == 1) && (r1 == 1);
          cevt = (r0 + r1 == 2);
        end
      end else if (r0 + r1 > 0) begin
        cevt = (m_rises < 2) && (m_rises + r0 + r1 >= 2);
        m_rises = m_rises + r0 + r1;
      end else if (!mst[0] && !mst[1]) begin
        m_in_ep = 1'b0;
      end
      e_busy = m_in_ep;
`ifdef BTN_CONFLICT_STICKY_EN
      if (cevt) e_conf = 1'b1;
      else if (e_p0 || e_p1) e_conf = 1'b0;
`else
      e_conf = cevt;
`endif
      for (int b = 0; b < 2; b++) begin
        mst_d[b] = mst[b];
        for (int j = S + D - 1; j > 0; j--) mh[b][j] = mh[b][j-1];
        mh[b][0] = (b == 0) ? btn0_raw : btn1_raw;
        allx = 1'b1;
        for (int j = S; j < S + D; j++) if (mh[b][j] == mst[b]) allx = 1'b0;
        if (allx) mst[b] = !mst[b];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    c_p0 = 0; c_p1 = 0; c_conf = 0; c_ovl = 0;
  endtask

  // Drive one cycle of inputs, advance past the edge, sample at the falling edge.
  task automatic cyc(input logic b0, input logic b1);
    btn0_raw = b0;
    btn1_raw = b1;
    @(posedge clk);
    @(negedge clk);
    if (pulse0) c_p0++;
    if (pulse1) c_p1++;
    if (conflict) c_conf++;
    if (pulse0 && pulse1) c_ovl++;
  endtask

  int found, conf_before, conf_at;
  int pq [$];
  int seq [5];
  int rem0, rem1;
  logic l0, l1;

  initial begin
    for (int i = 0; i < 24; i++) begin
      tbl[i].b0   = (i < 10);
      tbl[i].b1   = 1'b0;
      tbl[i].p0   = (i == 6);
      tbl[i].p1   = 1'b0;
      tbl[i].bsy  = (i >= 6 && i <= 15);
      tbl[i].conf = 1'b0;
    end
    for (int j = 0; j < 24; j++) begin
      tbl[24+j].b0   = 1'b0;
      tbl[24+j].b1   = (j == 0 || j == 2 || (j >= 4 && j <= 13));
      tbl[24+j].p0   = 1'b0;
      tbl[24+j].p1   = (j == 10);
      tbl[24+j].bsy  = (j >= 10 && j <= 19);
      tbl[24+j].conf = 1'b0;
    end

    reset = 1'b1; btn0_raw = 1'b0; btn1_raw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pulse0", pulse0, 0);
    chk("reset_pulse1", pulse1, 0);
    chk("reset_busy", busy, 0);
    chk("reset_conflict", conflict, 0);
    reset = 1'b0;
    repeat (10) cyc(1'b0, 1'b0);

    // Clean press of button 0, then bouncing press of button 1.
    for (int i = 0; i < 48; i++) begin
      cyc(tbl[i].b0, tbl[i].b1);
      chk($sformatf("vec%0d_pulse0", i), pulse0, tbl[i].p0);
      chk($sformatf("vec%0d_pulse1", i), pulse1, tbl[i].p1);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_conflict", i), conflict, tbl[i].conf);
    end

    // Reset in the middle of a held press; held button must not be accepted afterwards.
    repeat (8) cyc(1'b1, 1'b0);
    chk("midpress_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pulse0", pulse0, 0);
    chk("midrst_conflict", conflict, 0);
    @(negedge clk);
    repeat (3) cyc(1'b1, 1'b0);
    reset = 1'b0;
    clr_cnt();
    repeat (20) cyc(1'b1, 1'b0);
    chk("held_after_rst_pulses", c_p0, 0);
    chk("held_after_rst_busy", busy, 0);
    repeat (6) cyc(1'b0, 1'b0);
    chk("release_no_pulse", c_p0, 0);
    clr_cnt();
    found = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      if (pulse0 && found < 0) found = i;
    end
    chk("repress_pulse_time", found, 6);
    chk("repress_pulse_count", c_p0, 1);
    repeat (10) cyc(1'b0, 1'b0);

    // Password stream 0,1,0,1,1.
    seq = '{0, 1, 0, 1, 1};
    clr_cnt();
    pq.delete();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 16; i++) begin
        cyc((i < 8) && seq[p] == 0, (i < 8) && seq[p] == 1);
        if (pulse0) pq.push_back(0);
        if (pulse1) pq.push_back(1);
      end
    end
    repeat (4) cyc(1'b0, 1'b0);
    chk("pw_count", pq.size(), 5);
    for (int p = 0; p < 5; p++) begin
      if (p < pq.size()) chk($sformatf("pw_order%0d", p), pq[p], seq[p]);
      else chk($sformatf("pw_order%0d_missing", p), -1, seq[p]);
    end
    chk("pw_overlap", c_ovl, 0);
    chk("pw_busy_end", busy, 0);

    // Overlap: button 1 pressed while button 0 is still held.
    clr_cnt();
    found = -1;
    for (int i = 0; i < 20 && found < 0; i++) begin
      cyc(1'b1, 1'b0);
      if (pulse0) found = i;
    end
    chk("ovl_pulse0_time", found, 6);
    repeat (3) cyc(1'b1, 1'b0);
    repeat (12) cyc(1'b1, 1'b1);
    repeat (12) cyc(1'b0, 1'b0);
    chk("ovl_pulse0_count", c_p0, 1);
    chk("ovl_pulse1_count", c_p1, 0);
`ifdef BTN_CONFLICT_STICKY_EN
    chk("ovl_conflict_sticky", conflict, 1);
`else
    chk("ovl_conflict_cycles", c_conf, 1);
`endif
    chk("ovl_busy_end", busy, 0);

    // Simultaneous press of both buttons, then a clean button 1 press.
    clr_cnt();
    repeat (12) cyc(1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    chk("sim_pulse0_count", c_p0, 0);
    chk("sim_pulse1_count", c_p1, 0);
`ifdef BTN_CONFLICT_STICKY_EN
    chk("sim_conflict_sticky", conflict, 1);
`else
    chk("sim_conflict_cycles", c_conf, 1);
`endif
    chk("sim_busy_end", busy, 0);
    clr_cnt();
    found = -1; conf_before = -1; conf_at = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      if (i == 5) conf_before = conflict;
      if (pulse1 && found < 0) begin
        found = i;
        conf_at = conflict;
      end
    end
    chk("post_sim_pulse1_time", found, 6);
`ifdef BTN_CONFLICT_STICKY_EN
    chk("post_sim_conf_before", conf_before, 1);
`else
    chk("post_sim_conf_before", conf_before, 0);
`endif
    chk("post_sim_conf_at_pulse", conf_at, 0);
    repeat (10) cyc(1'b0, 1'b0);

    // Random bouncing/overlapping stimulus against the reference model.
    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);
    reset = 1'b0;
    repeat (10) cyc(1'b0, 1'b0);
    rem0 = 0; rem1 = 0; l0 = 1'b0; l1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rem0 == 0) begin l0 = ~l0; rem0 = $urandom_range(1, 14); end
      if (rem1 == 0) begin l1 = ~l1; rem1 = $urandom_range(1, 14); end
      rem0--; rem1--;
      cyc(l0, l1);
      chk($sformatf("rnd%0d_pulse0", i), pulse0, e_p0);
      chk($sformatf("rnd%0d_pulse1", i), pulse1, e_p1);
      chk($sformatf("rnd%0d_busy", i), busy, e_busy);
      chk($sformatf("rnd%0d_conflict", i), conflict, e_conf);
      chk($sformatf("rnd%0d_exclusive", i), pulse0 && pulse1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/btn_pulse_cond.md
Name: btn_pulse_cond

Overview:
Upstream conditioning stage for the two-button lock FSM.
- Takes raw, asynchronous, bouncy push-button levels btn0_raw and btn1_raw.
- Produces clean, mutually exclusive, single-cycle press pulses pulse0 and pulse1, which drive the lock's in0/in1 inputs directly.
- Guarantees one pulse per physical press.
- Suppresses both pulses when the two buttons overlap, and flags that condition on conflict.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in each raw-input synchronizer; legal range >= 2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized level must differ from the stable level before the stable level flips; legal range >= 1.
- CNT_W, 3: debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn0_raw  in  1  raw button 0 level, 1 = pressed, asynchronous to clk.
- btn1_raw  in  1  raw button 1 level, 1 = pressed, asynchronous to clk.
- pulse0  out  1  registered one-cycle pulse: accepted press of button 0.
- pulse1  out  1  registered one-cycle pulse: accepted press of button 1.
- busy  out  1  registered; 1 while the arbiter state is not IDLE.
- conflict  out  1  registered; overlap indication (see Optional Feature).

Behaviour:
- Reset: all synchronizer flops, stable levels and counters are 0; state = IDLE; pulse0 = pulse1 = busy = conflict = 0. Reset mid-press aborts the press; no pulse is emitted on deassertion, even if the button is still held. A held button is only accepted after it is released and pressed again.
- Synchronizer: per button, a SYNC_STAGES-deep flop chain; its output is s0/s1.
- Debounce, per button:
  - Counter increments each cycle in which s != stable.
  - Counter clears to 0 in any cycle in which s == stable (a glitch restarts the count).
  - When the counter equals DEBOUNCE_CYCLES-1 and s != stable, at that edge stable <= s and the counter clears.
  - Press edge (rise_n) = stable rising this cycle; release = stable falling.
- Latency: let k be the first edge sampling a new raw level that is then held.
  - The stable level flips at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - The pulse is high for exactly one cycle, following edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
  - With defaults: k+5 and k+6.
- Arbiter FSM states: IDLE, HOLD0, HOLD1, BOTH.
  - IDLE: rise0 only -> HOLD0, pulse0=1. rise1 only -> HOLD1, pulse1=1. rise0 and rise1 in the same cycle -> BOTH, no pulse.
  - HOLD0: rise1 -> BOTH. Stable0 falls and stable1=0 -> IDLE. No pulses.
  - HOLD1: symmetric to HOLD0.
  - BOTH: -> IDLE only when stable0 = stable1 = 0. No pulses.
  - Unused encodings -> IDLE.
- pulse0 and pulse1 are never high in the same cycle.
- A pulse is followed by at least one low cycle before the next pulse, since the FSM must leave HOLDx and pass through IDLE first.
- Release produces no pulse.
- conflict (default): one-cycle pulse on every transition into BOTH.

Optional Feature:
- Macro BTN_CONFLICT_STICKY_EN.
- When defined: conflict sets on entry to BOTH and stays 1. It clears only on reset, or in the cycle the next pulse0/pulse1 is emitted (the clear is registered together with that pulse).
- When undefined: conflict is a one-cycle pulse on entry to BOTH, as described above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset: assert reset mid-simulation with btn0_raw=1 held, then release reset -> all outputs 0; no pulse0 until btn0_raw goes 0 for >= 6 cycles and then 1 again.
2. Clean press, defaults: btn0_raw 0->1 sampled at edge k and held 10 cycles -> pulse0=1 only in the cycle after edge k+6; busy=1 from then until 6 cycles after release; pulse1 stays 0.
3. Bounce: btn1_raw toggles 1,0,1,0 on consecutive edges, then holds 1 -> exactly one pulse1, timed 6 edges after the start of the final held 1.
4. Password stream: apply clean presses in the order 0,1,0,1,1, each held 8 cycles with 8-cycle gaps -> exactly five pulses in order pulse0, pulse1, pulse0, pulse1, pulse1; no overlap.
5. Overlap: press btn0, then 3 cycles after pulse0 press btn1, then release both -> one pulse0, no pulse1, conflict high for 1 cycle; FSM returns to IDLE after both releases debounce.
6. Simultaneous press: both raw inputs rise on the same edge -> no pulses, conflict pulse. With BTN_CONFLICT_STICKY_EN: conflict stays 1 until the next clean btn1 press, then clears in the same cycle pulse1=1.
